// File: rtl/stack_seq.sv
// ---------------------------------------------------------------------------
// stack_seq
//   Multi-byte stack transfer sequencer for the 65C02 FSM core. It generates
//   page-1 bus cycles for pushes (PHA/PHP, JSR/BRK/IRQ/NMI) and pulls
//   (PLA/PLP/RTS/RTI). It drives the register file's S push/pull strobes and
//   assembles pulled bytes into the result registers.
//
//   Ports
//     clk, RST      clock, synchronous active-high reset
//     RDY           1 = bus cycle completes, 0 = stall
//     start, op     request and operation code (sampled in IDLE with RDY=1)
//     data_in       byte for PUSH1
//     pc_in, p_in   PC and status byte for PUSH2/PUSH3
//     S             stack pointer from the register file
//     DI            read data, valid the cycle after its address
//     push, pull    S decrement / increment strobes to the register file
//     stk_sel       block owns AB/DO/WE this cycle
//     AB, DO, WE    stack bus address, write data, write enable
//     busy, done    sequence in progress, one-cycle completion pulse
//     data_out      PULL1 result
//     pc_out        PULL2/PULL3 result
//     p_out         PULL3 result
//
//   state   | meaning
//   IDLE    | waiting for start
//   PUSH_H  | write PC high byte
//   PUSH_L  | write PC low byte
//   PUSH_P  | write status byte (PUSH3)
//   PUSH_D  | write data byte (PUSH1)
//   PULL_P  | read status byte (PULL3)
//   PULL_L  | read PC low byte
//   PULL_H  | read PC high byte
//   PULL_D  | read data byte (PULL1)
//   CAPT    | capture final pulled byte, no bus activity
//   DONE    | done pulse, then IDLE
// ---------------------------------------------------------------------------
module stack_seq #(
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        RDY,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  data_in,
    input  logic [15:0] pc_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  S,
    input  logic [7:0]  DI,
    output logic        push,
    output logic        pull,
    output logic        stk_sel,
    output logic [15:0] AB,
    output logic [7:0]  DO,
    output logic        WE,
    output logic        busy,
    output logic        done,
    output logic [7:0]  data_out,
    output logic [15:0] pc_out,
    output logic [7:0]  p_out
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_PUSH_H = 4'd1;
    localparam logic [3:0] ST_PUSH_L = 4'd2;
    localparam logic [3:0] ST_PUSH_P = 4'd3;
    localparam logic [3:0] ST_PUSH_D = 4'd4;
    localparam logic [3:0] ST_PULL_P = 4'd5;
    localparam logic [3:0] ST_PULL_L = 4'd6;
    localparam logic [3:0] ST_PULL_H = 4'd7;
    localparam logic [3:0] ST_PULL_D = 4'd8;
    localparam logic [3:0] ST_CAPT   = 4'd9;
    localparam logic [3:0] ST_DONE   = 4'd10;

    localparam logic [1:0] CAP_D = 2'd0;
    localparam logic [1:0] CAP_P = 2'd1;
    localparam logic [1:0] CAP_L = 2'd2;
    localparam logic [1:0] CAP_H = 2'd3;

    logic [3:0]  state;
    logic [3:0]  state_nx;
    logic [2:0]  op_r;
    logic [7:0]  data_r;
    logic [15:0] pc_r;
    logic [7:0]  p_r;
    logic        cap_pend;
    logic [1:0]  cap_sel;
    logic [1:0]  cap_sel_nx;
    logic        done_r;
    logic        is_push;
    logic        is_pull;
    logic        strobe_en;

    assign is_push = (state == ST_PUSH_H) || (state == ST_PUSH_L) ||
                     (state == ST_PUSH_P) || (state == ST_PUSH_D);
    assign is_pull = (state == ST_PULL_P) || (state == ST_PULL_L) ||
                     (state == ST_PULL_H) || (state == ST_PULL_D);

    // Strobes are suppressed during a stall and during the reset cycle so the
    // register file never sees an S update that the FSM does not follow.
    assign strobe_en = RDY && !RST;
    assign push      = is_push && strobe_en;
    assign WE        = is_push && strobe_en;
    assign pull      = is_pull && strobe_en;
    assign stk_sel   = is_push || is_pull;
    assign busy      = (state != ST_IDLE);
    assign done      = done_r;

    // Pulls address S+1 (pre-increment), pushes address S (post-decrement).
    assign AB = {STACK_PAGE, is_pull ? (S + 8'd1) : S};

    always_comb begin
        DO = 8'h00;
        case (state)
            ST_PUSH_H: DO = pc_r[15:8];
            ST_PUSH_L: DO = pc_r[7:0];
            ST_PUSH_P: DO = p_r;
            ST_PUSH_D: DO = data_r;
            default:   DO = 8'h00;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        3'd0:    state_nx = ST_PUSH_D;
                        3'd1:    state_nx = ST_PUSH_H;
                        3'd2:    state_nx = ST_PUSH_H;
                        3'd4:    state_nx = ST_PULL_D;
                        3'd5:    state_nx = ST_PULL_L;
                        3'd6:    state_nx = ST_PULL_P;
                        default: state_nx = ST_DONE;
                    endcase
                end
            end
            ST_PUSH_H: state_nx = ST_PUSH_L;
            ST_PUSH_L: state_nx = (op_r == 3'd2) ? ST_PUSH_P : ST_DONE;
            ST_PUSH_P: state_nx = ST_DONE;
            ST_PUSH_D: state_nx = ST_DONE;
            ST_PULL_P: state_nx = ST_PULL_L;
            ST_PULL_L: state_nx = ST_PULL_H;
            ST_PULL_H: state_nx = ST_CAPT;
            ST_PULL_D: state_nx = ST_CAPT;
            ST_CAPT:   state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Which result byte the data returned for this cycle's read belongs to.
    always_comb begin
        cap_sel_nx = CAP_D;
        case (state)
            ST_PULL_P: cap_sel_nx = CAP_P;
            ST_PULL_L: cap_sel_nx = CAP_L;
            ST_PULL_H: cap_sel_nx = CAP_H;
            default:   cap_sel_nx = CAP_D;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= ST_IDLE;
            op_r     <= 3'd0;
            data_r   <= 8'h00;
            pc_r     <= 16'h0000;
            p_r      <= 8'h00;
            cap_pend <= 1'b0;
            cap_sel  <= CAP_D;
            done_r   <= 1'b0;
            data_out <= 8'h00;
            pc_out   <= 16'h0000;
            p_out    <= 8'h00;
        end else if (RDY) begin
            state  <= state_nx;
            done_r <= (state_nx == ST_DONE);
            if ((state == ST_IDLE) && start) begin
                op_r   <= op;
                data_r <= data_in;
                pc_r   <= pc_in;
                p_r    <= p_in;
            end
            // DI answers the read issued in the previous completed cycle.
            if (cap_pend) begin
                case (cap_sel)
                    CAP_D:   data_out     <= DI;
                    CAP_P:   p_out        <= DI;
                    CAP_L:   pc_out[7:0]  <= DI;
                    default: pc_out[15:8] <= DI;
                endcase
            end
            cap_pend <= is_pull;
            cap_sel  <= cap_sel_nx;
        end else begin
            done_r <= 1'b0;
        end
    end

endmodule
